// File: rtl/pipe_scroll_ctrl.sv
// Scroll scheduler for the 16x16 pipe-game playfield: column buffer, step pacing, game FSM, score, collision.
// Optional PIPE_SCROLL_SPEEDUP_EN shortens the step period as the score grows.
module pipe_scroll_ctrl #(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned GAP_COLS = 4,
    parameter int unsigned BIRD_COL = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pipe_in,
    output logic        col_req,
    input  logic [3:0]  bird_row,
    input  logic [3:0]  rd_col,
    output logic [15:0] rd_data,
    output logic [1:0]  state,
    output logic [7:0]  score,
    output logic        hit
);

    localparam int unsigned NUM_COLS = 16;
    localparam int unsigned COL_W    = 16;
    localparam int unsigned SCORE_W  = 8;
    localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W    = (GAP_COLS > 0) ? $clog2(GAP_COLS + 1) : 1;
    localparam logic [3:0]  BIRD_IDX = 4'(BIRD_COL);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [COL_W-1:0]     r_col [NUM_COLS];
    logic [SCORE_W-1:0]   r_score;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [GAP_W-1:0]     r_gap_cnt;

    logic                 w_run;
    logic                 w_hit;
    logic                 w_div_last;
    logic                 w_step;
    logic                 w_clear;

    assign w_run   = (r_state == S_RUN);
    assign w_hit   = w_run && r_col[BIRD_IDX][bird_row];
    // A collision cancels any step landing on the same cycle.
    assign w_step  = w_run && w_div_last && !w_hit;
    assign w_clear = !w_run && start;

`ifdef PIPE_SCROLL_SPEEDUP_EN
    logic [31:0] w_dec;
    logic [31:0] w_base;
    logic [31:0] w_floor;
    logic [31:0] w_thr;

    // Threshold shrinks by TICK_DIV/4 per 8 points, floored at TICK_DIV/2 and at least 1.
    always_comb begin
        w_dec   = 32'(r_score >> 3) * 32'(TICK_DIV >> 2);
        w_floor = 32'(TICK_DIV >> 1);
        w_base  = (w_dec >= 32'(TICK_DIV)) ? 32'd0 : (32'(TICK_DIV) - w_dec);
        w_thr   = (w_base > w_floor) ? w_base : w_floor;
        if (w_thr == 32'd0) begin
            w_thr = 32'd1;
        end
        w_div_last = (32'(r_div_cnt) >= (w_thr - 32'd1));
    end
`else
    assign w_div_last = (r_div_cnt == DIV_W'(TICK_DIV - 1));
`endif

    // Game state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_hit) w_state_nxt = S_OVER;
            S_OVER:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Playfield buffer, divider, spacer counter and score.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                r_col[i] <= '0;
            end
            r_score   <= '0;
            r_div_cnt <= '0;
            r_gap_cnt <= '0;
        end else if (w_clear) begin
            for (int i = 0; i < NUM_COLS; i++) begin
                r_col[i] <= '0;
            end
            r_score   <= '0;
            r_div_cnt <= '0;
            r_gap_cnt <= '0;
        end else if (w_run) begin
            r_div_cnt <= w_div_last ? '0 : (r_div_cnt + DIV_W'(1));
            if (w_step) begin
                for (int i = 0; i < NUM_COLS - 1; i++) begin
                    r_col[i] <= r_col[i+1];
                end
                r_col[NUM_COLS-1] <= (r_gap_cnt == '0) ? pipe_in : '0;
                r_gap_cnt <= (r_gap_cnt == GAP_W'(GAP_COLS)) ? '0 : (r_gap_cnt + GAP_W'(1));
                if ((r_col[0] != '0) && (r_score != {SCORE_W{1'b1}})) begin
                    r_score <= r_score + SCORE_W'(1);
                end
            end
        end
    end

    assign col_req = w_step;
    assign hit     = w_hit;
    assign rd_data = r_col[rd_col];
    assign state   = r_state;
    assign score   = r_score;

endmodule
